// File: rtl/m_ext_defs.sv
// Shared M-extension definitions: funct3 encodings and controller state encoding.
package m_ext_defs;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/m_mul_ctrl.sv
// Multiply controller: decodes funct3, extends operands for a sibling 33x33
// multiplier, waits for its product and returns the selected 32-bit half.
// A one-entry reuse slot lets a repeat of the last operands skip the multiplier.
module m_mul_ctrl
  import m_ext_defs::*;
#(
  parameter int REUSE_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_kill,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic        o_mul_start,
  output logic [32:0] o_mul_a,
  output logic [32:0] o_mul_b,
  input  logic [63:0] i_mul_c,
  input  logic        i_mul_done
);

  state_t      state;
  logic        valid_q;
  logic        op_mul;
  logic        reuse_vld;
  logic [63:0] product;
  logic [31:0] result_q;

  logic        a_sgn;
  logic        b_sgn;
  logic [32:0] ext_a;
  logic [32:0] ext_b;
  logic        is_mul;
  logic        accept;
  logic        hit;
  logic [31:0] sel_half;

  // Operand extension, acceptance and reuse-hit detection for the request on the bus.
  // The last multiplier operands stay in o_mul_a/o_mul_b and double as the reuse tag.
  always_comb begin
    a_sgn  = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU);
    b_sgn  = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH);
    ext_a  = {a_sgn & i_rs1[31], i_rs1};
    ext_b  = {b_sgn & i_rs2[31], i_rs2};
    is_mul = (i_funct3 == F3_MUL);
    accept = (state == ST_IDLE) && i_valid && !i_kill && !i_funct3[2];
    hit    = 1'b0;
    if (REUSE_EN != 0 && reuse_vld) begin
      if (is_mul)
        hit = (o_mul_a[31:0] == i_rs1) && (o_mul_b[31:0] == i_rs2);
      else
        hit = (o_mul_a == ext_a) && (o_mul_b == ext_b);
    end
  end

  // Response half comes from the held product; a killed response leaves the
  // previously delivered result on o_result.
  always_comb begin
    sel_half = op_mul ? product[31:0] : product[63:32];
    o_valid  = valid_q && !i_kill;
    o_result = o_valid ? sel_half : result_q;
    o_ready  = (state == ST_IDLE);
  end

  // Controller FSM with registered strobes and the reuse entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      valid_q     <= 1'b0;
      op_mul      <= 1'b0;
      reuse_vld   <= 1'b0;
      product     <= '0;
      result_q    <= '0;
      o_mul_start <= 1'b0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
    end else begin
      o_mul_start <= 1'b0;
      valid_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_mul <= is_mul;
            if (hit) begin
              valid_q <= 1'b1;
              state   <= ST_RESP;
            end else begin
              // New operands overwrite the tag, so the old product is no longer reusable.
              o_mul_a     <= ext_a;
              o_mul_b     <= ext_b;
              o_mul_start <= 1'b1;
              reuse_vld   <= 1'b0;
              state       <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_kill) begin
            reuse_vld <= 1'b0;
            state     <= ST_IDLE;
          end else if (i_mul_done) begin
            product   <= i_mul_c;
            reuse_vld <= 1'b1;
            valid_q   <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!i_kill) result_q <= sel_half;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mul_ctrl.sv
// Directed bench for m_mul_ctrl: one instance with reuse, one without, each
// driven by a one-cycle-latency behavioural multiplier.
module tb_m_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid0 = 1'b0, valid1 = 1'b0, kill = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        fdone = 1'b0;
  logic        sel = 1'b0;

  logic        rdy0, vld0, st0, rdy1, vld1, st1;
  logic [31:0] res0, res1;
  logic [32:0] a0, b0, a1, b1;
  logic [63:0] mc0 = '0, mc1 = '0, c0;
  logic        md0 = 1'b0, md1 = 1'b0, done0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign done0 = md0 | fdone;
  assign c0    = fdone ? 64'h1234_5678_9ABC_DEF0 : mc0;

  m_mul_ctrl #(.REUSE_EN(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid0), .i_funct3(f3), .i_rs1(rs1), .i_rs2(rs2),
    .i_kill(kill), .o_ready(rdy0), .o_valid(vld0), .o_result(res0), .o_mul_start(st0),
    .o_mul_a(a0), .o_mul_b(b0), .i_mul_c(c0), .i_mul_done(done0));

  m_mul_ctrl #(.REUSE_EN(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid1), .i_funct3(f3), .i_rs1(rs1), .i_rs2(rs2),
    .i_kill(kill), .o_ready(rdy1), .o_valid(vld1), .o_result(res1), .o_mul_start(st1),
    .o_mul_a(a1), .o_mul_b(b1), .i_mul_c(mc1), .i_mul_done(md1));

  function automatic logic [63:0] prod(input logic [32:0] a, input logic [32:0] b);
    logic [65:0] ea, eb, p;
    ea = {{33{a[32]}}, a};
    eb = {{33{b[32]}}, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  // Behavioural multipliers: done one cycle after the start strobe.
  always @(posedge clk) begin
    md0 <= 1'b0;
    md1 <= 1'b0;
    if (st0) begin md0 <= 1'b1; mc0 <= prod(a0, b0); end
    if (st1) begin md1 <= 1'b1; mc1 <= prod(a1, b1); end
  end

  logic        g_rdy, g_vld, g_st;
  logic [31:0] g_res;
  logic [32:0] g_a, g_b;
  assign g_rdy = sel ? rdy1 : rdy0;
  assign g_vld = sel ? vld1 : vld0;
  assign g_st  = sel ? st1  : st0;
  assign g_res = sel ? res1 : res0;
  assign g_a   = sel ? a1   : a0;
  assign g_b   = sel ? b1   : b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request; miss expects start in N+1 and o_valid in N+3, hit expects o_valid in N+1.
  task automatic run_op(input string tag, input logic s, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic hit,
                        input logic [32:0] ea, input logic [32:0] eb, input logic [31:0] exp);
    @(negedge clk);
    sel = s;
    #1 chk({tag, "_ready"}, 64'(g_rdy), 64'd1);
    f3 = f; rs1 = a; rs2 = b;
    if (s) valid1 = 1'b1; else valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0; valid1 = 1'b0;
    if (hit) begin
      chk({tag, "_start_n1"}, 64'(g_st), 64'd0);
      chk({tag, "_valid_n1"}, 64'(g_vld), 64'd1);
      chk({tag, "_result"}, 64'(g_res), 64'(exp));
    end else begin
      chk({tag, "_start_n1"}, 64'(g_st), 64'd1);
      chk({tag, "_mul_a"}, 64'(g_a), 64'(ea));
      chk({tag, "_mul_b"}, 64'(g_b), 64'(eb));
      chk({tag, "_valid_n1"}, 64'(g_vld), 64'd0);
      @(negedge clk);
      chk({tag, "_start_n2"}, 64'(g_st), 64'd0);
      chk({tag, "_valid_n2"}, 64'(g_vld), 64'd0);
      chk({tag, "_mul_a_hold"}, 64'(g_a), 64'(ea));
      @(negedge clk);
      chk({tag, "_valid_n3"}, 64'(g_vld), 64'd1);
      chk({tag, "_result"}, 64'(g_res), 64'(exp));
    end
    @(negedge clk);
    chk({tag, "_valid_off"}, 64'(g_vld), 64'd0);
    chk({tag, "_ready_back"}, 64'(g_rdy), 64'd1);
    chk({tag, "_result_hold"}, 64'(g_res), 64'(exp));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_valid", 64'(vld0), 64'd0);
    chk("rst_result", 64'(res0), 64'd0);
    chk("rst_start", 64'(st0), 64'd0);
    chk("rst_mul_a", 64'(a0), 64'd0);
    chk("rst_mul_b", 64'(b0), 64'd0);
    rst = 1'b0;

    run_op("mul_neg", 0, 3'b000, 32'hFFFF_FFFF, 32'h2, 0, 33'h1_FFFF_FFFF, 33'h0_0000_0002, 32'hFFFF_FFFE);
    run_op("mulhu_ff", 0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh_ff", 0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 32'h0);
    run_op("mulhsu", 0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33'h1_8000_0000, 33'h0_FFFF_FFFF, 32'h8000_0000);

    // funct3[2]=1 is ignored
    @(negedge clk);
    f3 = 3'b100; rs1 = 32'd1; rs2 = 32'd1; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    chk("div_ign_start", 64'(st0), 64'd0);
    chk("div_ign_ready", 64'(rdy0), 64'd1);
    chk("div_ign_valid", 64'(vld0), 64'd0);
    @(negedge clk);
    chk("div_ign_valid2", 64'(vld0), 64'd0);

    // Reuse: high half then MUL on the same operands
    run_op("reuse_mulh", 0, 3'b001, 32'd3, 32'd5, 0, 33'd3, 33'd5, 32'd0);
    run_op("reuse_mul_hit", 0, 3'b000, 32'd3, 32'd5, 1, 33'd0, 33'd0, 32'd15);
    run_op("noreuse_mulh", 1, 3'b001, 32'd3, 32'd5, 0, 33'd3, 33'd5, 32'd0);
    run_op("noreuse_mul", 1, 3'b000, 32'd3, 32'd5, 0, 33'd3, 33'd5, 32'd15);

    // Kill in WAIT
    @(negedge clk);
    sel = 1'b0;
    f3 = 3'b011; rs1 = 32'h0001_0000; rs2 = 32'h0003_0000; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    chk("killw_start", 64'(st0), 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("killw_valid", 64'(vld0), 64'd0);
    chk("killw_ready", 64'(rdy0), 64'd1);
    @(negedge clk);
    chk("killw_valid2", 64'(vld0), 64'd0);
    run_op("killw_repeat", 0, 3'b011, 32'h0001_0000, 32'h0003_0000, 0, 33'h0_0001_0000, 33'h0_0003_0000, 32'd3);

    // Kill in RESP: no pulse, result held, product still reusable
    @(negedge clk);
    f3 = 3'b000; rs1 = 32'd6; rs2 = 32'd7; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    chk("killr_start", 64'(st0), 64'd1);
    @(negedge clk);
    @(negedge clk);
    kill = 1'b1;
    #1;
    chk("killr_valid", 64'(vld0), 64'd0);
    chk("killr_result", 64'(res0), 64'd3);
    @(negedge clk);
    kill = 1'b0;
    chk("killr_ready", 64'(rdy0), 64'd1);
    chk("killr_valid2", 64'(vld0), 64'd0);
    run_op("killr_hit", 0, 3'b000, 32'd6, 32'd7, 1, 33'd0, 33'd0, 32'd42);

    // Kill with valid in IDLE drops the request
    @(negedge clk);
    f3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; valid0 = 1'b1; kill = 1'b1;
    @(negedge clk);
    valid0 = 1'b0; kill = 1'b0;
    chk("killi_start", 64'(st0), 64'd0);
    chk("killi_ready", 64'(rdy0), 64'd1);
    chk("killi_valid", 64'(vld0), 64'd0);

    // Reset between edges during WAIT, then a late done
    @(negedge clk);
    f3 = 3'b000; rs1 = 32'h1234; rs2 = 32'h10; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    chk("rstw_start", 64'(st0), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstw_ready", 64'(rdy0), 64'd1);
    chk("rstw_valid", 64'(vld0), 64'd0);
    chk("rstw_result", 64'(res0), 64'd0);
    chk("rstw_start0", 64'(st0), 64'd0);
    chk("rstw_mul_a", 64'(a0), 64'd0);
    chk("rstw_mul_b", 64'(b0), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    fdone = 1'b1;
    @(negedge clk);
    fdone = 1'b0;
    chk("rstw_late_valid", 64'(vld0), 64'd0);
    chk("rstw_late_ready", 64'(rdy0), 64'd1);
    @(negedge clk);
    chk("rstw_late_valid2", 64'(vld0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/m_mul_ctrl.md
M_MUL_CTRL -- requirements
Module: m_mul_ctrl

Interface
REQ-001 SHALL have parameter REUSE_EN, default 1, enabling reuse of the last 64-bit product.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  core request strobe.
REQ-005 SHALL have port i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-006 SHALL have ports i_rs1, i_rs2  input  32  source operands.
REQ-007 SHALL have port i_kill  input  1  pipeline flush, aborts any in-flight operation.
REQ-008 SHALL have port o_ready  output  1  block can accept a request this cycle.
REQ-009 SHALL have ports o_valid (1) and o_result (32)  output  result strobe and data.
REQ-010 SHALL have ports o_mul_start (1), o_mul_a (33), o_mul_b (33)  output  drive the sibling multiplier.
REQ-011 SHALL have ports i_mul_c (64), i_mul_done (1)  input  multiplier product and completion.

Function
REQ-012 SHALL implement states IDLE, WAIT, RESP; o_ready=1 only in IDLE.
REQ-013 SHALL accept a request in IDLE when i_valid=1, i_kill=0 and i_funct3[2]=0; i_funct3[2]=1 requests are ignored, with no state change and no response.
REQ-014 SHALL extend operands: MUL and MULH sign-extend both; MULHSU sign-extends rs1 and zero-extends rs2; MULHU zero-extends both.
REQ-015 SHALL, on a miss, register the extended operands at acceptance edge N, pulse o_mul_start for exactly cycle N+1 with o_mul_a/o_mul_b stable, and enter WAIT.
REQ-016 SHALL hold o_mul_a/o_mul_b constant from N+1 until leaving WAIT.
REQ-017 SHALL, in WAIT with i_mul_done=1, capture i_mul_c into a 64-bit product register and enter RESP; nominal latency from acceptance to o_valid is 3 cycles (o_valid in N+3).
REQ-018 SHALL, in RESP, assert o_valid for exactly one cycle with o_result = product[31:0] for MUL and product[63:32] otherwise, then return to IDLE.
REQ-019 SHALL, with REUSE_EN=1 and a valid stored product, treat a request as a hit when MUL and the stored low 32 bits of both operands match, or when high-half and the full 33-bit extended operands match.
REQ-020 SHALL, on a hit, skip the multiplier (no o_mul_start) and go IDLE→RESP, giving o_valid in N+1.
REQ-021 SHALL ignore i_mul_done in IDLE and RESP; WAIT has no timeout.
REQ-022 SHALL, on i_kill=1 in WAIT, discard the product, invalidate the reuse entry and enter IDLE next cycle with no o_valid.
REQ-023 SHALL, on i_kill=1 in RESP, force o_valid=0 that cycle and return to IDLE; the stored product remains valid.
REQ-024 SHALL, on i_kill=1 and i_valid=1 together in IDLE, drop the request.
REQ-025 SHALL keep o_result stable between o_valid pulses.

Reset
REQ-026 SHALL, while i_rst=1, force state IDLE, o_ready=1, o_valid=0, o_result=0, o_mul_start=0, o_mul_a=0, o_mul_b=0, and invalidate the reuse entry, independent of i_clk.
REQ-027 SHALL, on reset during WAIT, abandon the operation; a late i_mul_done is ignored.

Structure
REQ-028 SHALL take the funct3 encodings and the state encoding from the shared package m_ext_defs.
REQ-029 SHALL contain no sub-module; operand extension is inline and the multiplier is a sibling instance wired by the parent.

Verification
REQ-030 SHALL test MUL rs1=0xFFFFFFFF, rs2=0x2 -> o_mul_a=0x1FFFFFFFF, o_mul_start in N+1, o_valid in N+3, o_result=0xFFFFFFFE.
REQ-031 SHALL test MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE, then MULH on the same operands -> miss (start pulsed), o_result=0x00000000.
REQ-032 SHALL test MULHSU rs1=0x80000000, rs2=0xFFFFFFFF -> o_mul_b=0x0FFFFFFFF, o_result=0x80000000.
REQ-033 SHALL test MULH 3×5 followed by MUL 3×5 -> second op has no o_mul_start, o_valid in N+1, o_result=15; same sequence with REUSE_EN=0 -> 3-cycle latency.
REQ-034 SHALL test i_kill in WAIT -> no o_valid, o_ready=1 next cycle, repeat request misses.
REQ-035 SHALL test i_rst asserted mid-WAIT between clock edges -> all outputs at reset values immediately, and a later i_mul_done produces no o_valid.
